// File: rtl/aes_pkg.sv
// Shared AES datapath constants and types used by the round-key blocks.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_COL_W   = 32;
  localparam int AES_COLS    = AES_BLOCK_W / AES_COL_W;

  // Round-key counts for AES-128, AES-192 and AES-256.
  localparam int AES_NUM_KEYS_128 = 11;
  localparam int AES_NUM_KEYS_192 = 13;
  localparam int AES_NUM_KEYS_256 = 15;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;

  function automatic bit aes_num_keys_legal(input int num_keys);
    return (num_keys == AES_NUM_KEYS_128) ||
           (num_keys == AES_NUM_KEYS_192) ||
           (num_keys == AES_NUM_KEYS_256);
  endfunction

endpackage

// File: rtl/addroundkey_lane.sv
// Combinational AddRoundKey slice: XORs one lane of state with the matching
// lane of the round key, or passes the state through when bypassed.
module addroundkey_lane
  import aes_pkg::*;
#(
  parameter int LANE_W = AES_COL_W
) (
  input  logic [LANE_W-1:0] state_i,
  input  logic [LANE_W-1:0] key_i,
  input  logic              bypass_i,
  output logic [LANE_W-1:0] result_o
);

  assign result_o = bypass_i ? state_i : (state_i ^ key_i);

endmodule

// File: rtl/addroundkey_serial.sv
// Column-serial AES AddRoundKey with on-chip round-key storage; processes
// COLS_PER_CYCLE columns per beat and registers the result for a handshake.
module addroundkey_serial
  import aes_pkg::*;
#(
  parameter  int COLS_PER_CYCLE = 1,
  parameter  int NUM_KEYS       = 11,
  localparam int ROUND_W        = $clog2(NUM_KEYS),
  localparam int BEATS          = 4 / COLS_PER_CYCLE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_we,
  input  logic [ROUND_W-1:0]  key_addr,
  input  logic [127:0]        key_wdata,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_state,
  input  logic [ROUND_W-1:0]  in_round,
  input  logic                in_bypass,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_state,
  output logic                out_err,
  output logic                busy
);

  localparam int LANE_W = COLS_PER_CYCLE * AES_COL_W;
  localparam int BEAT_W = $clog2(BEATS + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XOR  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        st_q, st_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  aes_block_t        work_q, work_d;
  aes_block_t        snap_q, snap_d;
  aes_block_t        out_q, out_d;
  logic              bypass_q, bypass_d;
  logic              err_q, err_d;

  aes_block_t        keys_q [NUM_KEYS];
  aes_block_t        key_rd;
  logic              round_ok;
  logic              in_fire;

  logic [LANE_W-1:0] lane_state;
  logic [LANE_W-1:0] lane_key;
  logic [LANE_W-1:0] lane_result;

  // Key RAM is deliberately left unreset; writes to nonexistent slots drop.
  always_ff @(posedge clk) begin
    if (key_we && (key_addr < ROUND_W'(NUM_KEYS))) begin
      keys_q[key_addr] <= key_wdata;
    end
  end

  assign round_ok = (in_round < ROUND_W'(NUM_KEYS));
  assign key_rd   = round_ok ? keys_q[in_round] : '0;

  assign in_ready  = rst_n && (st_q == ST_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (st_q == ST_DONE);
  assign busy      = (st_q != ST_IDLE);
  assign out_state = out_q;
  assign out_err   = err_q;

  always_comb begin
    lane_state = '0;
    lane_key   = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        lane_state = work_q[AES_BLOCK_W-1-b*LANE_W -: LANE_W];
        lane_key   = snap_q[AES_BLOCK_W-1-b*LANE_W -: LANE_W];
      end
    end
  end

  addroundkey_lane #(
    .LANE_W (LANE_W)
  ) u_lane (
    .state_i  (lane_state),
    .key_i    (lane_key),
    .bypass_i (bypass_q),
    .result_o (lane_result)
  );

  // An out-of-range round is folded into bypass so the state passes unchanged.
  always_comb begin
    st_d     = st_q;
    beat_d   = beat_q;
    work_d   = work_q;
    snap_d   = snap_q;
    out_d    = out_q;
    bypass_d = bypass_q;
    err_d    = err_q;
    case (st_q)
      ST_IDLE: begin
        if (in_fire) begin
          st_d     = ST_XOR;
          beat_d   = '0;
          work_d   = in_state;
          snap_d   = key_rd;
          bypass_d = in_bypass || !round_ok;
          err_d    = !round_ok;
        end
      end
      ST_XOR: begin
        if (beat_q == BEAT_W'(BEATS)) begin
          out_d = work_q;
          st_d  = ST_DONE;
        end else begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
              work_d[AES_BLOCK_W-1-b*LANE_W -: LANE_W] = lane_result;
            end
          end
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      beat_q   <= '0;
      work_q   <= '0;
      snap_q   <= '0;
      out_q    <= '0;
      bypass_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      beat_q   <= beat_d;
      work_q   <= work_d;
      snap_q   <= snap_d;
      out_q    <= out_d;
      bypass_q <= bypass_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_addroundkey_serial.sv
// Drives three addroundkey_serial instances (1, 2 and 4 columns per cycle)
// in lockstep and checks each against a block-level AddRoundKey model.
module tb_addroundkey_serial;

  localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_STATE = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_OUT   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_we;
  logic [3:0]   key_addr;
  logic [127:0] key_wdata;
  logic         in_valid;
  logic [127:0] in_state;
  logic [3:0]   in_round;
  logic         in_bypass;
  logic         out_ready;

  logic [2:0]   in_ready_w;
  logic [2:0]   out_valid_w;
  logic [2:0]   out_err_w;
  logic [2:0]   busy_w;
  logic [127:0] out_state_w [3];

  logic [127:0] key_model [11];
  logic [127:0] last_out [3];
  int           tests_run;
  int           tests_failed;

  always #5 clk = ~clk;

  addroundkey_serial #(.COLS_PER_CYCLE(1), .NUM_KEYS(11)) u_c1 (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_addr(key_addr),
    .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_state(in_state), .in_round(in_round), .in_bypass(in_bypass),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_state(out_state_w[0]), .out_err(out_err_w[0]), .busy(busy_w[0])
  );

  addroundkey_serial #(.COLS_PER_CYCLE(2), .NUM_KEYS(11)) u_c2 (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_addr(key_addr),
    .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_state(in_state), .in_round(in_round), .in_bypass(in_bypass),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_state(out_state_w[1]), .out_err(out_err_w[1]), .busy(busy_w[1])
  );

  addroundkey_serial #(.COLS_PER_CYCLE(4), .NUM_KEYS(11)) u_c4 (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_addr(key_addr),
    .key_wdata(key_wdata), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .in_state(in_state), .in_round(in_round), .in_bypass(in_bypass),
    .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .out_state(out_state_w[2]), .out_err(out_err_w[2]), .busy(busy_w[2])
  );

  // Instance d processes 1 << d columns per cycle, hence 4 >> d beats.
  function automatic int beatsOf(input int d);
    return 4 >> d;
  endfunction

  function automatic logic [127:0] refModel(input logic [127:0] st, input logic [3:0] rnd,
                                            input logic byp);
    if (rnd >= 4'd11 || byp) return st;
    return st ^ key_model[rnd];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic writeKey(input logic [3:0] addr, input logic [127:0] data);
    key_we    = 1'b1;
    key_addr  = addr;
    key_wdata = data;
    @(negedge clk);
    key_we = 1'b0;
    if (addr < 4'd11) key_model[addr] = data;
  endtask

  // One block through all instances; optional key write launched at hz_cyc.
  task automatic applyStimulus(input logic [127:0] st, input logic [3:0] rnd, input logic byp,
                               input int hz_cyc, input logic [3:0] hz_addr,
                               input logic [127:0] hz_data, input string tag);
    logic [127:0] exp_state;
    logic         exp_err;
    int           lat [3];
    exp_state = refModel(st, rnd, byp);
    exp_err   = (rnd >= 4'd11);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("%s_c%0d_in_ready", tag, d), 128'(in_ready_w[d]), 128'(1));
      lat[d] = 0;
    end
    out_ready = 1'b1;
    in_state  = st;
    in_round  = rnd;
    in_bypass = byp;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      if (cyc == hz_cyc) begin
        key_we    = 1'b1;
        key_addr  = hz_addr;
        key_wdata = hz_data;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (key_we) begin
        key_we = 1'b0;
        if (hz_addr < 4'd11) key_model[hz_addr] = hz_data;
      end
      for (int d = 0; d < 3; d++) begin
        if (cyc > 0 && out_valid_w[d] && lat[d] == 0) begin
          lat[d]      = cyc;
          last_out[d] = out_state_w[d];
          checkOutput($sformatf("%s_c%0d_state", tag, d), out_state_w[d], exp_state);
          checkOutput($sformatf("%s_c%0d_err", tag, d), 128'(out_err_w[d]), 128'(exp_err));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("%s_c%0d_latency", tag, d), 128'(lat[d]), 128'(beatsOf(d) + 1));
    end
  endtask

  initial begin
    logic [127:0] st;
    logic [127:0] held_state;
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    key_we    = 1'b0;
    key_addr  = '0;
    key_wdata = '0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_round  = '0;
    in_bypass = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("rst_c%0d_in_ready", d), 128'(in_ready_w[d]), 128'(0));
      checkOutput($sformatf("rst_c%0d_out_valid", d), 128'(out_valid_w[d]), 128'(0));
      checkOutput($sformatf("rst_c%0d_busy", d), 128'(busy_w[d]), 128'(0));
      checkOutput($sformatf("rst_c%0d_out_err", d), 128'(out_err_w[d]), 128'(0));
      checkOutput($sformatf("rst_c%0d_out_state", d), out_state_w[d], 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    writeKey(4'd0, FIPS_KEY);
    applyStimulus(FIPS_STATE, 4'd0, 1'b0, -1, 4'd0, '0, "fips");
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("fips_vec_c%0d", d), last_out[d], FIPS_OUT);

    writeKey(4'd3, {16{8'h4A}});
    applyStimulus({16{8'h1C}}, 4'd3, 1'b0, -1, 4'd0, '0, "byte_1c");
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("byte_56_c%0d", d), last_out[d], {16{8'h56}});
    writeKey(4'd5, {16{8'h7F}});
    applyStimulus({16{8'h06}}, 4'd5, 1'b0, -1, 4'd0, '0, "byte_06");
    writeKey(4'd7, {16{8'h0D}});
    applyStimulus({16{8'hC3}}, 4'd7, 1'b0, -1, 4'd0, '0, "byte_c3");

    for (int a = 0; a < 11; a++) writeKey(4'(a), rand128());
    for (int i = 0; i < 10; i++)
      applyStimulus(rand128(), 4'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0),
                    -1, 4'd0, '0, $sformatf("rand%0d", i));

    applyStimulus(rand128(), 4'd11, 1'b0, -1, 4'd0, '0, "err_round11");
    applyStimulus(rand128(), 4'd15, 1'b0, -1, 4'd0, '0, "err_round15");
    applyStimulus(rand128(), 4'd2, 1'b1, -1, 4'd0, '0, "bypass");
    writeKey(4'd12, rand128());
    applyStimulus(rand128(), 4'd9, 1'b0, 0, 4'd9, rand128(), "rbw");
    applyStimulus(rand128(), 4'd9, 1'b0, -1, 4'd0, '0, "rbw_next");

    // Backpressure: hold results for 7 cycles while a second block is offered.
    st          = rand128();
    out_ready   = 1'b0;
    in_state    = st;
    in_round    = 4'd4;
    in_bypass   = 1'b0;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    held_state = refModel(st, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("bp%0d_c%0d_valid", i, d), 128'(out_valid_w[d]), 128'(1));
        checkOutput($sformatf("bp%0d_c%0d_state", i, d), out_state_w[d], held_state);
        checkOutput($sformatf("bp%0d_c%0d_in_ready", i, d), 128'(in_ready_w[d]), 128'(0));
      end
      in_state = rand128();
      in_round = 4'd1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("bp_release_c%0d_valid", d), 128'(out_valid_w[d]), 128'(0));
      checkOutput($sformatf("bp_release_c%0d_in_ready", d), 128'(in_ready_w[d]), 128'(1));
    end
    applyStimulus(rand128(), 4'd6, 1'b0, -1, 4'd0, '0, "after_bp");

    // Key hazard: key[0] rewritten to zero during beat 1 of an in-flight block.
    writeKey(4'd0, FIPS_KEY);
    applyStimulus(FIPS_STATE, 4'd0, 1'b0, 2, 4'd0, '0, "hazard");
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("hazard_vec_c%0d", d), last_out[d], FIPS_OUT);
    applyStimulus(FIPS_STATE, 4'd0, 1'b0, -1, 4'd0, '0, "zero_key");
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("zero_key_vec_c%0d", d), last_out[d], FIPS_STATE);

    // Reset in the middle of an erroring block.
    out_ready = 1'b0;
    in_state  = rand128();
    in_round  = 4'd11;
    in_bypass = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("mid_c%0d_busy", d), 128'(busy_w[d]), 128'(1));
      checkOutput($sformatf("mid_c%0d_err", d), 128'(out_err_w[d]), 128'(1));
    end
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("midrst_c%0d_valid", d), 128'(out_valid_w[d]), 128'(0));
      checkOutput($sformatf("midrst_c%0d_state", d), out_state_w[d], 128'(0));
      checkOutput($sformatf("midrst_c%0d_err", d), 128'(out_err_w[d]), 128'(0));
      checkOutput($sformatf("midrst_c%0d_busy", d), 128'(busy_w[d]), 128'(0));
      checkOutput($sformatf("midrst_c%0d_in_ready", d), 128'(in_ready_w[d]), 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("postrst_c%0d_in_ready", d), 128'(in_ready_w[d]), 128'(1));
    applyStimulus(rand128(), 4'd3, 1'b0, -1, 4'd0, '0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/addroundkey_serial.md
ADDROUNDKEY_SERIAL -- requirements
Module: addroundkey_serial

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, giving the 32-bit state columns XORed per cycle; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter NUM_KEYS, default 11, giving the round keys stored; legal values are 11, 13 and 15 (AES-128/192/256).
REQ-003 SHALL derive localparam ROUND_W = clog2(NUM_KEYS) and localparam BEATS = 4/COLS_PER_CYCLE.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk (input, 1) is the rising-edge clock for all state; rst_n (input, 1) is the synchronous active-low reset.
REQ-005 SHALL have key_we (input, 1), the round-key write strobe.
REQ-006 SHALL have key_addr (input, ROUND_W), the round-key write index.
REQ-007 SHALL have key_wdata (input, 128), the round-key write data.
REQ-008 SHALL have in_valid (input, 1) and in_ready (output, 1), the input-block handshake.
REQ-009 SHALL have in_state (input, 128), the input state, and in_round (input, ROUND_W), the index of the key to apply.
REQ-010 SHALL have in_bypass (input, 1); when high the block passes the state through without XOR.
REQ-011 SHALL have out_valid (input-facing output, 1) and out_ready (input, 1), the output-block handshake.
REQ-012 SHALL have out_state (output, 128), the result, and out_err (output, 1), flagging an out-of-range round index.
REQ-013 SHALL have busy (output, 1), high whenever the state is not IDLE.

Function
REQ-014 SHALL order each 128-bit block column-major as in FIPS-197: column c occupies bits [127-32c : 96-32c], and byte 0 is the MSB.
REQ-015 SHALL use three FSM states: IDLE → XOR on an input handshake; XOR → DONE after BEATS beats; DONE → IDLE on an output handshake.
REQ-016 SHALL drive in_ready high only in IDLE, and out_valid high only in DONE.
REQ-017 SHALL, on an input handshake, capture in_state, in_bypass and the error condition, and latch a snapshot of key[in_round].
REQ-018 SHALL, in XOR beat k (k = 0..BEATS-1), replace columns k·COLS_PER_CYCLE .. k·COLS_PER_CYCLE+COLS_PER_CYCLE-1 of the working register with (state XOR key), or with state unchanged when bypass is set.
REQ-019 SHALL assert out_valid exactly BEATS+1 cycles after the input-handshake edge, i.e. latency 2/3/5 cycles for COLS_PER_CYCLE 4/2/1.
REQ-020 SHALL hold out_state, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL give minimum issue interval BEATS+2 cycles, because in_ready returns in the cycle after the output handshake.
REQ-022 SHALL, when in_round ≥ NUM_KEYS, still accept the block, return out_state = in_state unmodified, and set out_err=1; otherwise out_err=0.
REQ-023 SHALL accept key writes in any state; a write targeting a slot that is in use does not disturb the in-flight block, because the snapshot is taken at acceptance.
REQ-024 SHALL, when a key write and an input handshake hit the same index in the same cycle, latch the old key (read-before-write).
REQ-025 SHALL ignore key_we when key_addr ≥ NUM_KEYS.
REQ-026 SHALL ignore in_valid outside IDLE.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, enter IDLE and clear out_valid, out_err, busy, out_state and the working and snapshot registers to 0, aborting any block in flight.
REQ-028 SHALL hold in_ready low in every cycle in which rst_n=0.
REQ-029 SHALL not clear the round-key storage on reset; its contents are undefined until written.

Structure
REQ-030 SHALL take from shared package aes_pkg the constants AES_BLOCK_W=128 and AES_COL_W=32, the typedef aes_block_t (128-bit), and the legal NUM_KEYS values.
REQ-031 SHALL instantiate one combinational sub-module, addroundkey_lane, which XORs (or bypasses) COLS_PER_CYCLE·32 bits.
REQ-032 SHALL implement key storage as a register array of NUM_KEYS × 128 bits with one write port and one read port.

Verification
REQ-033 SHALL pass the FIPS-197 vector: key[0]=2b7e151628aed2a6abf7158809cf4f3c, state 3243f6a8885a308d313198a2e0370734, round 0 → 193de3bea0f4e22b9ac68d2ae9f84808, out_err=0, for each COLS_PER_CYCLE in {1, 2, 4} at latency BEATS+1.
REQ-034 SHALL pass byte checks: all state bytes 0x1C with key[3] all 0x4A → all 0x56; 0x06 with 0x7F → 0x79; 0xC3 with 0x0D → 0xCE.
REQ-035 SHALL show backpressure: with out_ready held low for 7 cycles, out_state is stable, in_ready=0, and a second in_valid is ignored; the result is released when out_ready rises.
REQ-036 SHALL show errors and bypass: in_round=NUM_KEYS → out_state=in_state, out_err=1; in_bypass=1 with a valid round → out_state=in_state, out_err=0.
REQ-037 SHALL show key hazard: rewriting key[0] to 0 during beat 1 → result still equals the REQ-033 value; the next block uses the zero key.
REQ-038 SHALL show reset mid-block: rst_n low for 1 cycle during XOR → IDLE, all outputs 0, in_ready=1 on the following cycle, and the next block completes correctly.
